qlearn_phase_sequencer: RTL and testbench

- Top-level round controller for the routing-learning core.
- Each round runs three sub-blocks in fixed order: find-best (FB), winner policy (WP), update (UP), using their en / start / done handshakes.
- Owns the single shared memory port (11-bit address, 16-bit data) and the shared RNG enable, and routes them to whichever sub-block is active.
- Runs a programmable number of rounds per start and aborts on a per-phase watchdog timeout.

---
 rtl/qlearn_phase_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_qlearn_phase_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/qlearn_phase_sequencer.sv
// Round controller for the routing-learning core. It runs find-best, winner
// policy and update in turn each round, and routes the shared memory/RNG port to the active phase.
//
// state     | meaning
// ----------+--------------------------------------------------
// IDLE      | waiting for start
// FB_EN     | re-arm find-best (en_fb pulse)
// FB_START  | start find-best, clear watchdog
// FB_WAIT   | wait for done_fb under watchdog
// WP_EN     | re-arm winner policy
// WP_START  | start winner policy, clear watchdog
// WP_WAIT   | wait for done_wp under watchdog
// UP_EN     | re-arm update
// UP_START  | start update, clear watchdog
// UP_WAIT   | wait for done_up, then count the round
// FINISH    | normal end of run, done pulse
// ERR       | watchdog abort, done pulse with sticky error
module qlearn_phase_sequencer #(
    parameter int TIMEOUT = 1023,
    parameter int CNT_W   = 16
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_rounds,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  round_count,
    output logic              en_fb,
    output logic              en_wp,
    output logic              en_up,
    output logic              start_fb,
    output logic              start_wp,
    output logic              start_up,
    input  logic              done_fb,
    input  logic              done_wp,
    input  logic              done_up,
    input  logic [10:0]       fb_address,
    input  logic [10:0]       wp_address,
    input  logic [10:0]       up_address,
    input  logic              fb_wr_en,
    input  logic              wp_wr_en,
    input  logic              up_wr_en,
    input  logic [15:0]       fb_data_out,
    input  logic [15:0]       wp_data_out,
    input  logic [15:0]       up_data_out,
    input  logic              fb_en_rng,
    input  logic              wp_en_rng,
    input  logic              up_en_rng,
    output logic [10:0]       mem_address,
    output logic              mem_wr_en,
    output logic [15:0]       mem_data_out,
    output logic              en_rng
);

    typedef enum logic [3:0] {
        S_IDLE, S_FB_EN, S_FB_START, S_FB_WAIT,
        S_WP_EN, S_WP_START, S_WP_WAIT,
        S_UP_EN, S_UP_START, S_UP_WAIT,
        S_FINISH, S_ERR
    } state_t;

    typedef enum logic [1:0] {OWN_NONE, OWN_FB, OWN_WP, OWN_UP} owner_t;

    state_t           state, state_nxt;
    owner_t           owner, owner_nxt;
    logic [CNT_W-1:0] watchdog;
    logic [CNT_W-1:0] rounds_target;
    logic [CNT_W-1:0] round_cnt;
    logic             in_wait;
    logic             phase_done;
    logic             wd_expired;
    logic             last_round;

    assign in_wait     = (state == S_FB_WAIT) || (state == S_WP_WAIT) || (state == S_UP_WAIT);
    assign wd_expired  = (watchdog == CNT_W'(TIMEOUT - 1));
    assign last_round  = ((round_cnt + CNT_W'(1)) == rounds_target);
    assign round_count = round_cnt;

    always_comb begin
        phase_done = 1'b0;
        case (state)
            S_FB_WAIT: phase_done = done_fb;
            S_WP_WAIT: phase_done = done_wp;
            S_UP_WAIT: phase_done = done_up;
            default:   phase_done = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state         <= S_IDLE;
            owner         <= OWN_NONE;
            watchdog      <= '0;
            rounds_target <= '0;
            round_cnt     <= '0;
            error         <= 1'b0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            if (state == S_IDLE && start) begin
                rounds_target <= num_rounds;
                round_cnt     <= '0;
                error         <= 1'b0;
            end
            if (state == S_FB_START || state == S_WP_START || state == S_UP_START)
                watchdog <= '0;
            else if (in_wait && !phase_done)
                watchdog <= watchdog + CNT_W'(1);
            if (state == S_UP_WAIT && done_up)
                round_cnt <= round_cnt + CNT_W'(1);
            if (state_nxt == S_ERR)
                error <= 1'b1;
        end
    end

    // done in a WAIT state takes priority over a simultaneous watchdog expiry
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (start) state_nxt = (num_rounds == '0) ? S_FINISH : S_FB_EN;
            S_FB_EN:    state_nxt = S_FB_START;
            S_FB_START: state_nxt = S_FB_WAIT;
            S_FB_WAIT:  if (done_fb) state_nxt = S_WP_EN;
                        else if (wd_expired) state_nxt = S_ERR;
            S_WP_EN:    state_nxt = S_WP_START;
            S_WP_START: state_nxt = S_WP_WAIT;
            S_WP_WAIT:  if (done_wp) state_nxt = S_UP_EN;
                        else if (wd_expired) state_nxt = S_ERR;
            S_UP_EN:    state_nxt = S_UP_START;
            S_UP_START: state_nxt = S_UP_WAIT;
            S_UP_WAIT:  if (done_up) state_nxt = last_round ? S_FINISH : S_FB_EN;
                        else if (wd_expired) state_nxt = S_ERR;
            default:    state_nxt = S_IDLE;
        endcase

        owner_nxt = OWN_NONE;
        case (state_nxt)
            S_FB_EN, S_FB_START, S_FB_WAIT: owner_nxt = OWN_FB;
            S_WP_EN, S_WP_START, S_WP_WAIT: owner_nxt = OWN_WP;
            S_UP_EN, S_UP_START, S_UP_WAIT: owner_nxt = OWN_UP;
            default:                        owner_nxt = OWN_NONE;
        endcase
    end

    always_comb begin
        busy     = !(state == S_IDLE || state == S_FINISH || state == S_ERR);
        done     = (state == S_FINISH) || (state == S_ERR);
        en_fb    = (state == S_FB_EN);
        en_wp    = (state == S_WP_EN);
        en_up    = (state == S_UP_EN);
        start_fb = (state == S_FB_START);
        start_wp = (state == S_WP_START);
        start_up = (state == S_UP_START);

        mem_address  = '0;
        mem_wr_en    = 1'b0;
        mem_data_out = '0;
        en_rng       = 1'b0;
        case (owner)
            OWN_FB: begin
                mem_address  = fb_address;
                mem_wr_en    = fb_wr_en;
                mem_data_out = fb_data_out;
                en_rng       = fb_en_rng;
            end
            OWN_WP: begin
                mem_address  = wp_address;
                mem_wr_en    = wp_wr_en;
                mem_data_out = wp_data_out;
                en_rng       = wp_en_rng;
            end
            OWN_UP: begin
                mem_address  = up_address;
                mem_wr_en    = up_wr_en;
                mem_data_out = up_data_out;
                en_rng       = up_en_rng;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_qlearn_phase_sequencer.sv
// Directed bench for qlearn_phase_sequencer with stub sub-blocks that
// answer 4 cycles after their start pulse.
module tb_qlearn_phase_sequencer;

    localparam int TO = 16;

    logic        clock = 1'b0;
    logic        rst, start;
    logic [15:0] num_rounds;
    logic        busy, done, error;
    logic [15:0] round_count;
    logic        en_fb, en_wp, en_up, start_fb, start_wp, start_up;
    logic        done_fb, done_wp, done_up;
    logic [10:0] fb_address, wp_address, up_address;
    logic        fb_wr_en, wp_wr_en, up_wr_en;
    logic [15:0] fb_data_out, wp_data_out, up_data_out;
    logic        fb_en_rng, wp_en_rng, up_en_rng;
    logic [10:0] mem_address;
    logic        mem_wr_en;
    logic [15:0] mem_data_out;
    logic        en_rng;

    always #5 clock = ~clock;

    qlearn_phase_sequencer #(.TIMEOUT(TO), .CNT_W(16)) dut (
        .clock(clock), .rst(rst), .start(start), .num_rounds(num_rounds),
        .busy(busy), .done(done), .error(error), .round_count(round_count),
        .en_fb(en_fb), .en_wp(en_wp), .en_up(en_up),
        .start_fb(start_fb), .start_wp(start_wp), .start_up(start_up),
        .done_fb(done_fb), .done_wp(done_wp), .done_up(done_up),
        .fb_address(fb_address), .wp_address(wp_address), .up_address(up_address),
        .fb_wr_en(fb_wr_en), .wp_wr_en(wp_wr_en), .up_wr_en(up_wr_en),
        .fb_data_out(fb_data_out), .wp_data_out(wp_data_out), .up_data_out(up_data_out),
        .fb_en_rng(fb_en_rng), .wp_en_rng(wp_en_rng), .up_en_rng(up_en_rng),
        .mem_address(mem_address), .mem_wr_en(mem_wr_en),
        .mem_data_out(mem_data_out), .en_rng(en_rng)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // stub sub-blocks: done level rises 4 cycles after start, cleared by en
    logic [2:0] cnt_fb = 0, cnt_wp = 0, cnt_up = 0;
    logic       arm_fb = 0, arm_wp = 0, arm_up = 0;
    logic       stall_wp = 0;

    always @(posedge clock) begin
        if (en_fb) arm_fb <= 1'b0;
        else if (start_fb) begin arm_fb <= 1'b1; cnt_fb <= 3'd4; end
        else if (cnt_fb != 0) cnt_fb <= cnt_fb - 3'd1;
        if (en_wp) arm_wp <= 1'b0;
        else if (start_wp) begin arm_wp <= 1'b1; cnt_wp <= 3'd4; end
        else if (cnt_wp != 0) cnt_wp <= cnt_wp - 3'd1;
        if (en_up) arm_up <= 1'b0;
        else if (start_up) begin arm_up <= 1'b1; cnt_up <= 3'd4; end
        else if (cnt_up != 0) cnt_up <= cnt_up - 3'd1;
    end

    assign done_fb = arm_fb && (cnt_fb == 0);
    assign done_wp = arm_wp && (cnt_wp == 0) && !stall_wp;
    assign done_up = arm_up && (cnt_up == 0);

    int   ev_q[$];
    int   rc_q[$];
    int   done_pulses = 0;
    logic done_busy   = 1'b0;
    logic log_on      = 1'b0;

    always @(negedge clock) begin
        if (log_on) begin
            if (en_fb) begin ev_q.push_back(1); rc_q.push_back(int'(round_count)); end
            if (start_fb) ev_q.push_back(2);
            if (en_wp)    ev_q.push_back(3);
            if (start_wp) ev_q.push_back(4);
            if (en_up)    ev_q.push_back(5);
            if (start_up) ev_q.push_back(6);
            if (done) begin
                done_pulses++;
                done_busy = done_busy | busy;
            end
        end
    end

    task automatic clear_logs();
        ev_q.delete();
        rc_q.delete();
        done_pulses = 0;
        done_busy   = 1'b0;
    endtask

    task automatic clear_buses();
        fb_address = '0; wp_address = '0; up_address = '0;
        fb_wr_en = 0; wp_wr_en = 0; up_wr_en = 0;
        fb_data_out = '0; wp_data_out = '0; up_data_out = '0;
        fb_en_rng = 0; wp_en_rng = 0; up_en_rng = 0;
    endtask

    // returns at the negedge following the edge that samples start
    task automatic do_start(input logic [15:0] n);
        @(negedge clock);
        start = 1'b1;
        num_rounds = n;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int cycles);
        cycles = 0;
        while (!done && cycles < budget) begin
            @(negedge clock);
            cycles++;
        end
        check_val(tag, done, 1);
    endtask

    task automatic wait_pulse(input string tag, input int which, input int budget);
        int n = 0;
        while (!((which == 0) ? start_fb : start_wp) && n < budget) begin
            @(negedge clock);
            n++;
        end
        check_val(tag, (which == 0) ? start_fb : start_wp, 1);
    endtask

    function automatic int count_ev(input int code);
        int c = 0;
        foreach (ev_q[i]) if (ev_q[i] == code) c++;
        return c;
    endfunction

    initial begin
        int cyc;
        int exp_seq[12] = '{1, 2, 3, 4, 5, 6, 1, 2, 3, 4, 5, 6};

        // reset with random inputs
        rst = 1'b1;
        start = 1'(($urandom));
        num_rounds = 16'($urandom);
        fb_address = 11'($urandom); wp_address = 11'($urandom); up_address = 11'($urandom);
        fb_wr_en = 1'($urandom); wp_wr_en = 1'($urandom); up_wr_en = 1'($urandom);
        fb_data_out = 16'($urandom); wp_data_out = 16'($urandom); up_data_out = 16'($urandom);
        fb_en_rng = 1'($urandom); wp_en_rng = 1'($urandom); up_en_rng = 1'($urandom);
        repeat (2) @(negedge clock);
        check_val("rst_status", {busy, done, error}, 0);
        check_val("rst_round_count", round_count, 0);
        check_val("rst_pulses", {en_fb, en_wp, en_up, start_fb, start_wp, start_up}, 0);
        check_val("rst_mem_bus", {mem_address, mem_wr_en, mem_data_out, en_rng}, 0);
        start = 1'b0;
        fb_wr_en = 1'b1;
        fb_address = 11'h7FF;
        rst = 1'b0;
        @(negedge clock);
        check_val("idle_mem_wr_en", mem_wr_en, 0);
        check_val("idle_mem_address", mem_address, 0);
        clear_buses();

        // two full rounds
        log_on = 1'b1;
        clear_logs();
        do_start(16'd2);
        wait_done("t2_wait_done", 200, cyc);
        check_val("t2_run_cycles", cyc, 42);
        check_val("t2_busy_at_done", busy, 0);
        check_val("t2_error", error, 0);
        check_val("t2_round_count", round_count, 2);
        @(negedge clock);
        check_val("t2_done_single", done, 0);
        check_val("t2_done_pulses", done_pulses, 1);
        check_val("t2_done_busy", done_busy, 0);
        check_val("t2_event_count", ev_q.size(), 12);
        if (ev_q.size() == 12)
            foreach (exp_seq[i]) check_val($sformatf("t2_event_%0d", i), ev_q[i], exp_seq[i]);
        check_val("t2_rc_samples", rc_q.size(), 2);
        if (rc_q.size() == 2) begin
            check_val("t2_rc_round1", rc_q[0], 0);
            check_val("t2_rc_round2", rc_q[1], 1);
        end

        // shared-bus routing
        fb_address = 11'h7FF; fb_wr_en = 1'b1; fb_data_out = 16'hFFFF;
        wp_address = 11'h004; wp_wr_en = 1'b1; wp_data_out = 16'h0012;
        up_address = 11'h155; up_wr_en = 1'b0; up_data_out = 16'hA5A5; up_en_rng = 1'b1;
        do_start(16'd1);
        check_val("t3_fb_bus", {mem_address, mem_wr_en, mem_data_out, en_rng},
                  {11'h7FF, 1'b1, 16'hFFFF, 1'b0});
        wait_pulse("t3_wait_start_wp", 1, 50);
        @(negedge clock);
        check_val("t3_wp_address", mem_address, 11'h004);
        check_val("t3_wp_wr_en", mem_wr_en, 1);
        check_val("t3_wp_data", mem_data_out, 16'h0012);
        check_val("t3_en_rng_isolated", en_rng, 0);
        wp_en_rng = 1'b1;
        #1;
        check_val("t3_en_rng_owner", en_rng, 1);
        wait_done("t3_wait_done", 100, cyc);
        check_val("t3_round_count", round_count, 1);
        clear_buses();

        // watchdog abort in WP_WAIT
        stall_wp = 1'b1;
        fb_address = 11'h7FF; fb_wr_en = 1'b1;
        wp_address = 11'h004; wp_wr_en = 1'b1;
        @(negedge clock);
        clear_logs();
        do_start(16'd1);
        wait_pulse("t4_wait_start_wp", 1, 50);
        wait_done("t4_wait_done", 100, cyc);
        check_val("t4_abort_cycles", cyc, TO + 1);
        check_val("t4_error", error, 1);
        check_val("t4_busy", busy, 0);
        check_val("t4_round_count", round_count, 0);
        check_val("t4_owner_none", {mem_address, mem_wr_en}, 0);
        @(negedge clock);
        check_val("t4_error_sticky", error, 1);
        check_val("t4_done_single", done, 0);
        check_val("t4_no_start_up", count_ev(6), 0);
        stall_wp = 1'b0;
        clear_buses();
        do_start(16'd1);
        check_val("t4_error_cleared", error, 0);
        wait_done("t4_rerun_done", 100, cyc);
        check_val("t4_rerun_rounds", round_count, 1);

        // zero rounds
        @(negedge clock);
        clear_logs();
        do_start(16'd0);
        check_val("t5_done", done, 1);
        check_val("t5_busy", busy, 0);
        @(negedge clock);
        check_val("t5_done_single", done, 0);
        check_val("t5_no_pulses", ev_q.size(), 0);
        check_val("t5_round_count", round_count, 0);

        // start ignored while running, then rst mid-run
        clear_logs();
        do_start(16'd1);
        wait_pulse("t6_wait_start_fb", 0, 50);
        @(negedge clock);
        start = 1'b1;
        num_rounds = 16'd5;
        @(negedge clock);
        start = 1'b0;
        wait_done("t6_wait_done", 100, cyc);
        check_val("t6_round_count", round_count, 1);
        @(negedge clock);
        check_val("t6_event_count", ev_q.size(), 6);

        wp_address = 11'h004; wp_wr_en = 1'b1;
        do_start(16'd3);
        wait_pulse("t6_wait_start_wp", 1, 50);
        @(negedge clock);
        rst = 1'b1;
        @(negedge clock);
        rst = 1'b0;
        check_val("t6_rst_status", {busy, done, error}, 0);
        check_val("t6_rst_pulses", {en_fb, en_wp, en_up, start_fb, start_wp, start_up}, 0);
        check_val("t6_rst_mem", {mem_address, mem_wr_en}, 0);
        clear_buses();
        do_start(16'd1);
        wait_done("t6_after_rst_done", 100, cyc);
        check_val("t6_after_rst_cycles", cyc, 21);
        check_val("t6_after_rst_rounds", round_count, 1);
        check_val("t6_after_rst_error", error, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
